// File: rtl/multiplicador_4bit_secuencial_pkg.sv
// rtl/multiplicador_4bit_secuencial_pkg.sv - shared ALU definitions: FSM states, iteration count, opcodes
package multiplicador_4bit_secuencial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int MUL_ITER = 4;
  localparam int CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  // Reserved opcode space for the wider ALU.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;

endpackage

// File: rtl/sumador_4bit.sv
// rtl/sumador_4bit.sv - 4-bit ripple-carry adder
module sumador_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Ci;
    for (int i = 0; i < 4; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[4];
  end

endmodule

// File: rtl/multiplicador_4bit_secuencial.sv
// rtl/multiplicador_4bit_secuencial.sv - sequential shift-and-add 4x4 unsigned multiplier
module multiplicador_4bit_secuencial
  import multiplicador_4bit_secuencial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] m, m_next;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] sum;
  logic             cout;

  sumador_4bit u_sumador (
    .A    (acc),
    .B    (m),
    .Ci   (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      m     <= '0;
      q     <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      m     <= m_next;
      q     <= q_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    m_next     = m;
    q_next     = q;
    acc_next   = acc;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          m_next     = A;
          q_next     = B;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        // Adder carry becomes the new acc MSB so the full 8-bit product survives.
        if (q[0]) {acc_next, q_next} = {cout, sum, q[WIDTH-1:1]};
        else      {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_LAST) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign P    = {acc, q};
  assign busy = (state == ST_CALC) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule
